mul_div_unit: RTL and testbench

Iterative multi-cycle multiply/divide unit in the EX stage, operating in parallel with the combinational ALU. It receives the same two 32-bit operands the ALU receives. It produces a 64-bit result into HI/LO registers for MULT/MULTU/DIV/DIVU. While it is busy, its busy flag drives the hazard logic, which stalls the pipeline.

---
 rtl/mul_div_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//
// Iterative multiply/divide unit for the EX stage. It runs alongside the
// combinational ALU on the same two operands and writes a 2*WIDTH-bit result
// into HI/LO. While it works, busy_o stalls the pipeline through the hazard
// logic.
//
// Multiply uses shift-add and divide uses restoring shift-subtract. Both
// produce one bit per clock and share a single 2*WIDTH accumulator. Signed
// operations run on operand magnitudes, and the FIX state applies the sign
// correction afterwards.
//
// Ports:
//   clk_i       system clock, all state updates on the rising edge
//   rst_i       synchronous reset, active-low
//   start_i     request a new operation (sampled only in IDLE)
//   op_i        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src1_i      multiplicand / dividend
//   src2_i      multiplier / divisor
//   busy_o      high whenever the unit is not IDLE
//   done_o      one-cycle pulse when HI/LO hold a new result
//   hi_o        MUL: upper product, DIV: remainder
//   lo_o        MUL: lower product, DIV: quotient
//   div_zero_o  last completed op was a divide by zero
//
// Build option:
//   MULDIV_EARLY_EXIT_EN  when defined, a multiply leaves CALC as soon as no
//                         multiplier bits remain. The accumulator is then
//                         shifted into its final position in one step.
//                         Results are the same with or without this option.
// -----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_nxt;

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               div_zero_q;

  // Operand decode at start time. op_i[0] low selects the signed variants.
  logic             start_signed;
  logic             src1_neg;
  logic             src2_neg;
  logic             start_dz;
  logic [WIDTH-1:0] src1_mag;
  logic [WIDTH-1:0] src2_mag;

  assign start_signed = ~op_i[0];
  assign src1_neg     = start_signed & src1_i[WIDTH-1];
  assign src2_neg     = start_signed & src2_i[WIDTH-1];
  assign src1_mag     = src1_neg ? (-src1_i) : src1_i;
  assign src2_mag     = src2_neg ? (-src2_i) : src2_i;
  assign start_dz     = op_i[1] & (src2_i == '0);

  // Multiply step. The low half of acc initially holds the multiplier. Each
  // step consumes bit 0 and shifts the partial product right into its place.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_nxt;

  assign mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step. acc holds {remainder, dividend/quotient}. The next dividend
  // bit is shifted into the remainder, and the divisor is subtracted when it
  // fits. A trial value below 2*divisor leaves a difference that fits in
  // WIDTH bits, so the subtraction is done at WIDTH bits.
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_acc_nxt;

  assign div_trial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge      = div_trial >= {1'b0, opnd_q};
  assign div_sub     = div_trial[WIDTH-1:0] - opnd_q;
  assign div_rem     = div_ge ? div_sub : div_trial[WIDTH-1:0];
  assign div_acc_nxt = {div_rem, acc_q[WIDTH-2:0], div_ge};

  logic last_iter;
  logic exit_early;

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_EXIT_EN
  // mplr_q tracks the multiplier bits above the one consumed this cycle.
  // When they are all zero, the rest of the product is only a right shift.
  logic [WIDTH-2:0]   mplr_q;
  logic [CNT_W-1:0]   early_shamt;
  logic [2*WIDTH-1:0] early_acc;

  assign exit_early  = ~is_div_q & (mplr_q == '0);
  assign early_shamt = CNT_W'(WIDTH - 1) - cnt_q;
  assign early_acc   = mul_acc_nxt >> early_shamt;
`else
  assign exit_early = 1'b0;
`endif

  // Sign-corrected results written in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   dz_hi;

  assign prod_fix = neg_res_q ? (-acc_q) : acc_q;
  assign quo_fix  = neg_res_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  // The dividend magnitude and its sign are enough to rebuild the raw src1.
  assign dz_hi    = neg_rem_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // A divide by zero leaves CALC after its first cycle and goes straight to
  // DONE, which skips both the iterations and FIX.
  always_comb begin
    state_nxt = state_q;
    busy_o    = 1'b1;
    done_o    = 1'b0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_nxt = CALC;
      end
      CALC: begin
        if (dz_q)                         state_nxt = DONE;
        else if (last_iter || exit_early) state_nxt = FIX;
      end
      FIX: begin
        state_nxt = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc_q      <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
      mplr_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            is_div_q   <= op_i[1];
            neg_res_q  <= src1_neg ^ src2_neg;
            neg_rem_q  <= src1_neg;
            dz_q       <= start_dz;
            div_zero_q <= 1'b0;
            cnt_q      <= '0;
            if (op_i[1]) begin
              acc_q  <= {{WIDTH{1'b0}}, src1_mag};
              opnd_q <= src2_mag;
            end else begin
              acc_q  <= {{WIDTH{1'b0}}, src2_mag};
              opnd_q <= src1_mag;
            end
`ifdef MULDIV_EARLY_EXIT_EN
            mplr_q <= src2_mag[WIDTH-1:1];
`endif
          end
        end
        CALC: begin
          if (dz_q) begin
            hi_q       <= dz_hi;
            lo_q       <= '1;
            div_zero_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (is_div_q) begin
              acc_q <= div_acc_nxt;
            end else begin
`ifdef MULDIV_EARLY_EXIT_EN
              acc_q  <= exit_early ? early_acc : mul_acc_nxt;
              mplr_q <= mplr_q >> 1;
`else
              acc_q <= mul_acc_nxt;
`endif
            end
          end
        end
        FIX: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//
// Directed testbench for mul_div_unit. The expected values are computed by
// hand. It covers signed and unsigned multiply and divide, divide by zero,
// starts ignored while busy, and reset in the middle of an operation.
// Multiply latency follows MULDIV_EARLY_EXIT_EN when that macro is defined.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int total;
  int bad;
  int lat;
  int busy_cnt;

  mul_div_unit #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .src1_i     (src1),
    .src2_i     (src2),
    .busy_o     (busy),
    .done_o     (done),
    .hi_o       (hi),
    .lo_o       (lo),
    .div_zero_o (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected cycles from the start edge to done for a multiply, given the
  // multiplier magnitude.
  function automatic int mulLat(input logic [31:0] mag);
`ifdef MULDIV_EARLY_EXIT_EN
    int n;
    n = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
    return n + 1;
`else
    return (mag == 32'd0) ? 33 : 33;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents start for one edge (E0) and returns 1ns after that edge.
  task automatic startOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src1  = a;
    src2  = b;
    tick();
    start = 1'b0;
  endtask

  // Runs one operation to completion. lat is the number of edges after E0
  // at which done is seen, and busy_cnt is the number of cycles busy is high.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    startOp(o, a, b);
    cyc      = 0;
    lat      = -1;
    busy_cnt = 0;
    while (busy && cyc < 200) begin
      busy_cnt++;
      if (done) lat = cyc;
      tick();
      cyc++;
    end
    if (cyc >= 200) checkOutput("timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int cyc;
    int pulses;
    int done_cyc;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    src1  = '0;
    src2  = '0;

    tick();
    tick();
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_hi", {32'd0, hi}, 64'd0);
    checkOutput("rst_lo", {32'd0, lo}, 64'd0);
    checkOutput("rst_dz", {63'd0, div_zero}, 64'd0);
    rst = 1'b1;
    tick();

    // Signed multiply: -3 * 7 = -21
    applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd7);
    checkOutput("mult_lat", 64'(lat), 64'(mulLat(32'd7)));
    checkOutput("mult_hi", {32'd0, hi}, 64'hFFFFFFFF);
    checkOutput("mult_lo", {32'd0, lo}, 64'hFFFFFFEB);
    checkOutput("mult_dz", {63'd0, div_zero}, 64'd0);

    // Largest unsigned product, which also gives the full busy window.
    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checkOutput("multu_hi", {32'd0, hi}, 64'hFFFFFFFE);
    checkOutput("multu_lo", {32'd0, lo}, 64'h00000001);
    checkOutput("multu_busy", 64'(busy_cnt), 64'd34);

    // Most negative squared: 2^62
    applyStimulus(OP_MULT, 32'h80000000, 32'h80000000);
    checkOutput("mult_min_hi", {32'd0, hi}, 64'h40000000);
    checkOutput("mult_min_lo", {32'd0, lo}, 64'h00000000);

    // Multiply by zero
    applyStimulus(OP_MULTU, 32'h12345678, 32'd0);
    checkOutput("mul0_lat", 64'(lat), 64'(mulLat(32'd0)));
    checkOutput("mul0_hilo", {hi, lo}, 64'd0);

    // Signed divide: -7 / 2 = -3 rem -1
    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2);
    checkOutput("div_lat", 64'(lat), 64'd33);
    checkOutput("div_lo", {32'd0, lo}, 64'hFFFFFFFD);
    checkOutput("div_hi", {32'd0, hi}, 64'hFFFFFFFF);

    // 7 / -2 = -3 rem 1
    applyStimulus(OP_DIV, 32'd7, 32'hFFFFFFFE);
    checkOutput("div_nd_lo", {32'd0, lo}, 64'hFFFFFFFD);
    checkOutput("div_nd_hi", {32'd0, hi}, 64'h00000001);

    // Overflow case wraps without a trap
    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    checkOutput("div_ovf_lo", {32'd0, lo}, 64'h80000000);
    checkOutput("div_ovf_hi", {32'd0, hi}, 64'h00000000);

    // Unsigned divide: 0xFFFFFFF9 / 2 = 0x7FFFFFFC rem 1
    applyStimulus(OP_DIVU, 32'hFFFFFFF9, 32'd2);
    checkOutput("divu_lo", {32'd0, lo}, 64'h7FFFFFFC);
    checkOutput("divu_hi", {32'd0, hi}, 64'h00000001);

    // Divide by zero finishes one cycle after the start edge
    applyStimulus(OP_DIVU, 32'h00001234, 32'd0);
    checkOutput("dz_lat", 64'(lat), 64'd1);
    checkOutput("dz_busy", 64'(busy_cnt), 64'd2);
    checkOutput("dz_hi", {32'd0, hi}, 64'h00001234);
    checkOutput("dz_lo", {32'd0, lo}, 64'hFFFFFFFF);
    checkOutput("dz_flag", {63'd0, div_zero}, 64'd1);

    // Signed divide by zero returns the raw dividend in hi
    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd0);
    checkOutput("sdz_hi", {32'd0, hi}, 64'hFFFFFFF9);
    checkOutput("sdz_flag", {63'd0, div_zero}, 64'd1);

    // The next accepted start clears the flag
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    checkOutput("dz_clear", {63'd0, div_zero}, 64'd0);
    checkOutput("divu7_lo", {32'd0, lo}, 64'd14);
    checkOutput("divu7_hi", {32'd0, hi}, 64'd2);

    // Starts while busy are ignored, both mid-CALC and during DONE
    startOp(OP_MULTU, 32'd5, 32'd6);
    cyc = 0;
`ifdef MULDIV_EARLY_EXIT_EN
    while (cyc < 2) begin tick(); cyc++; end
`else
    while (cyc < 10) begin tick(); cyc++; end
`endif
    start = 1'b1;
    src1  = 32'd9;
    src2  = 32'd9;
    tick();
    cyc++;
    start = 1'b0;
    while (!done && cyc < 200) begin tick(); cyc++; end
    done_cyc = cyc;
    checkOutput("ign_lat", 64'(done_cyc), 64'(mulLat(32'd6)));
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("ign_lo", {32'd0, lo}, 64'd30);
    checkOutput("ign_hi", {32'd0, hi}, 64'd0);
    checkOutput("ign_busy", {63'd0, busy}, 64'd0);
    tick();
    checkOutput("ign_idle", {63'd0, busy}, 64'd0);
    applyStimulus(OP_MULTU, 32'd9, 32'd9);
    checkOutput("fresh_lo", {32'd0, lo}, 64'd81);

    // Reset in the middle of a divide aborts it
    startOp(OP_DIV, 32'd1000, 32'd3);
    cyc = 0;
    while (cyc < 15) begin tick(); cyc++; end
    rst = 1'b0;
    tick();
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_hilo", {hi, lo}, 64'd0);
    checkOutput("abort_done", {63'd0, done}, 64'd0);
    rst    = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      tick();
    end
    checkOutput("abort_pulses", 64'(pulses), 64'd0);
    applyStimulus(OP_MULT, 32'd4, 32'd4);
    checkOutput("post_rst_lo", {32'd0, lo}, 64'd16);
    checkOutput("post_rst_hi", {32'd0, hi}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
